// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv
// Programmable glitch-free 50%-duty even clock divider; Y period = 2*(DIV+1) CLK cycles, Y registered (1-cycle latency).
// No backpressure: ratio changes and stop requests wait for the next Y 1->0 boundary so no runt phase escapes.
module gf180mcu_osu_sc_gp12t3v3__clkdiv_prog #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  output logic             Y,
  output logic             STOPPED,
  output logic             UPD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_act, div_act_nxt;
  logic             y_q, y_nxt;
  logic             stopped_q, stopped_nxt;
  logic             upd_q, upd_nxt;
  logic             wrap;
  logic             boundary;

  assign wrap     = (cnt == div_act);
  // A period ends on the edge that drops Y; only there may the ratio change or the divider stop.
  assign boundary = wrap && y_q;

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state     <= IDLE;
      cnt       <= '0;
      div_act   <= '0;
      y_q       <= 1'b0;
      stopped_q <= 1'b1;
      upd_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      div_act   <= div_act_nxt;
      y_q       <= y_nxt;
      stopped_q <= stopped_nxt;
      upd_q     <= upd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    div_act_nxt = div_act;
    y_nxt       = y_q;
    stopped_nxt = stopped_q;
    upd_nxt     = 1'b0;

    case (state)
      IDLE: begin
        y_nxt       = 1'b0;
        cnt_nxt     = '0;
        stopped_nxt = 1'b1;
        if (EN) begin
          state_nxt   = RUN;
          div_act_nxt = DIV;
          upd_nxt     = (DIV != div_act);
          stopped_nxt = 1'b0;
        end
      end

      RUN, DRAIN: begin
        if (wrap) begin
          cnt_nxt = '0;
          y_nxt   = ~y_q;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end

        if (state == RUN || EN) begin
          // EN seen in DRAIN resumes RUN seamlessly; a boundary on that edge reloads like RUN.
          state_nxt = EN ? RUN : DRAIN;
          if (boundary) begin
            div_act_nxt = DIV;
            upd_nxt     = (DIV != div_act);
          end
        end else if (boundary) begin
          state_nxt   = IDLE;
          y_nxt       = 1'b0;
          cnt_nxt     = '0;
          stopped_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        y_nxt       = 1'b0;
        cnt_nxt     = '0;
        stopped_nxt = 1'b1;
      end
    endcase
  end

  assign Y       = y_q;
  assign STOPPED = stopped_q;
  assign UPD     = upd_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv
// Directed bench for the programmable clock divider; outputs sampled 1 time unit after each rising CLK edge.
module tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_prog;

  logic       clk;
  logic       r;
  logic       en;
  logic [3:0] div;
  logic       y;
  logic       stopped;
  logic       upd;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int stp_cnt = 0;

  gf180mcu_osu_sc_gp12t3v3__clkdiv_prog #(.WIDTH(4)) dut (
    .CLK     (clk),
    .R       (r),
    .EN      (en),
    .DIV     (div),
    .Y       (y),
    .STOPPED (stopped),
    .UPD     (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps n edges, comparing Y after each against pat, MSB first; tallies UPD and STOPPED highs.
  task automatic chk_y(input string tag, input int n, input logic [63:0] pat);
    for (int i = 0; i < n; i++) begin
      step();
      if (upd === 1'b1) upd_cnt++;
      if (stopped === 1'b1) stp_cnt++;
      checks++;
      assert (y === pat[n-1-i]) else begin
        errors++;
        $error("FAIL %s edge %0d observed y=%b expected y=%b", tag, i, y, pat[n-1-i]);
      end
    end
  endtask

  initial begin
    r   = 1'b1;
    en  = 1'b0;
    div = 4'd0;
    #3;
    chk("rst_y", y, 1'b0);
    chk("rst_stopped", stopped, 1'b1);
    chk("rst_upd", upd, 1'b0);
    #9 r = 1'b0;
    step();
    chk("idle_y", y, 1'b0);
    chk("idle_stopped", stopped, 1'b1);

    // Start with DIV=3: rise 4 edges after entry, 4/4 period
    div = 4'd3;
    en  = 1'b1;
    step();
    chk("start_upd", upd, 1'b1);
    chk("start_stopped", stopped, 1'b0);
    chk("start_y", y, 1'b0);
    upd_cnt = 0;
    stp_cnt = 0;
    chk_y("div3_p1", 8, 64'b00011110);
    chk_y("div3_p2", 8, 64'b00011110);
    chk("div3_upd_cnt", upd_cnt, 0);
    chk("div3_stp_cnt", stp_cnt, 0);

    // Move to DIV=1, then request DIV=5 in the middle of a high phase
    div = 4'd1;
    upd_cnt = 0;
    chk_y("to_div1", 8, 64'b00011110);
    chk("to_div1_upd", upd_cnt, 1);
    chk_y("div1_lo_hi", 2, 64'b01);
    upd_cnt = 0;
    div = 4'd5;
    chk_y("div1_to_5", 14, 64'b1_000000_111111_0);
    chk("div5_upd", upd_cnt, 1);

    // DIV=2, drop EN during the low phase: 3/3 completes then park low
    div = 4'd2;
    upd_cnt = 0;
    chk_y("to_div2", 12, 64'b000001111110);
    chk("to_div2_upd", upd_cnt, 1);
    chk_y("div2_lo", 1, 64'b0);
    en = 1'b0;
    chk_y("drain_tail", 4, 64'b0111);
    chk("drain_stopped_pre", stopped, 1'b0);
    chk_y("drain_bound", 1, 64'b0);
    chk("drain_stopped_post", stopped, 1'b1);
    chk("drain_upd", upd, 1'b0);
    stp_cnt = 0;
    chk_y("idle_park", 2, 64'b00);
    chk("idle_park_stp", stp_cnt, 2);

    // Restart with unchanged ratio: no UPD; drain then resume with no gap
    en = 1'b1;
    step();
    chk("restart_upd", upd, 1'b0);
    chk("restart_stopped", stopped, 1'b0);
    stp_cnt = 0;
    chk_y("resume_a", 3, 64'b001);
    en = 1'b0;
    chk_y("resume_b", 1, 64'b1);
    en = 1'b1;
    chk_y("resume_c", 8, 64'b10001110);
    chk("resume_stp_cnt", stp_cnt, 0);

    // DIV=0 toggles every edge, then DIV=15 gives period 32
    div = 4'd0;
    upd_cnt = 0;
    chk_y("div0", 10, 64'b0011101010);
    chk("div0_upd", upd_cnt, 1);
    div = 4'd15;
    upd_cnt = 0;
    chk_y("div15", 34, {1'b1, 16'h0000, 16'hFFFF, 1'b0});
    chk("div15_upd", upd_cnt, 1);

    // Async reset while Y is high
    chk_y("div15_to_hi", 16, 64'h0001);
    #2 r = 1'b1;
    #1;
    chk("arst_y", y, 1'b0);
    chk("arst_stopped", stopped, 1'b1);
    chk("arst_upd", upd, 1'b0);
    step();
    chk("arst_hold_y", y, 1'b0);
    #2 r = 1'b0;
    div = 4'd3;
    step();
    chk("rerun_upd", upd, 1'b1);
    chk("rerun_stopped", stopped, 1'b0);
    chk_y("rerun_div3", 8, 64'b00011110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
